// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter: FSM state encoding and
// the parity / stop-bit parameter encodings.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  typedef enum logic {
    PARITY_NONE = 1'b0,
    PARITY_EVEN = 1'b1
  } parity_e;

  typedef enum logic [1:0] {
    STOP_ONE = 2'd1,
    STOP_TWO = 2'd2
  } stop_e;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and ticks on the
// last count; pre_tick flags the cycle before so callers can register a pulse.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick     = en && !clr && (cnt_q == LAST);
  assign pre_tick = en && !clr && (cnt_q == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops frames from a sync FIFO (rd_en/dout/empty).
// state | meaning: IDLE wait | POP rd_en pulse | LOAD capture dout | START | DATA | PARITY | STOP
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IW = 4;
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = (STOP_BITS == int'(STOP_TWO)) ? 4'd1 : 4'd0;
  localparam bit HAS_PARITY = (PARITY_EN == int'(PARITY_EVEN));

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic                  arm_q, arm_d;
  logic                  baud_clr, baud_en, tick, pre_tick;

  assign baud_en = (state_q == START) || (state_q == DATA) ||
                   (state_q == PARITY) || (state_q == STOP);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .en       (baud_en),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;
    arm_d    = 1'b1;
    baud_clr = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // arm_q holds off the first pop for one edge after reset release
        if (arm_q && tx_enable && !fifo_empty) begin
          state_d = POP;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      POP: state_d = LOAD;
      LOAD: begin
        shift_d  = fifo_dout;
        par_d    = ^fifo_dout;
        idx_d    = '0;
        baud_clr = 1'b1;
        tx_d     = 1'b0;
        state_d  = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (HAS_PARITY) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      STOP: begin
        if (idx_q == STOP_LAST && pre_tick) done_d = 1'b1;
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
      arm_q   <= arm_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (plain 8N1 and 8E2) fed by queue-based
// FIFO models; frames are compared against waveforms built from the frame rules.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       en_a = 1'b0, en_b = 1'b0;
  logic       empty_a = 1'b1, empty_b = 1'b1;
  logic [7:0] dout_a = '0, dout_b = '0;
  logic       rd_a, rd_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int rd_cnt_a = 0, rd_cnt_b = 0, under_a = 0, under_b = 0;
  int checks = 0, failures = 0;

  // Sync FIFO models: empty is registered from the pre-pop occupancy (stale).
  always @(posedge clk) begin
    empty_a <= (q_a.size() == 0);
    if (rd_a) begin
      rd_cnt_a++;
      if (q_a.size() == 0) under_a++;
      else dout_a <= q_a.pop_front();
    end
  end

  always @(posedge clk) begin
    empty_b <= (q_b.size() == 0);
    if (rd_b) begin
      rd_cnt_b++;
      if (q_b.size() == 0) under_b++;
      else dout_b <= q_b.pop_front();
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_dout(dout_a), .fifo_rd_en(rd_a),
    .tx_enable(en_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a));

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_dout(dout_b), .fifo_rd_en(rd_b),
    .tx_enable(en_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b));

  function automatic logic cur_tx(input int sel);   return (sel != 0) ? tx_b : tx_a;     endfunction
  function automatic logic cur_busy(input int sel); return (sel != 0) ? busy_b : busy_a; endfunction
  function automatic logic cur_done(input int sel); return (sel != 0) ? done_b : done_a; endfunction
  function automatic int   cur_rd(input int sel);   return (sel != 0) ? rd_cnt_b : rd_cnt_a; endfunction

  task automatic push(input int sel, input logic [7:0] b);
    if (sel != 0) q_b.push_back(b);
    else          q_a.push_back(b);
  endtask

  // Waits for the start bit, then records one whole frame and compares it.
  task automatic check_frame(input int sel, input logic [7:0] b, input string name);
    int p = (sel != 0) ? 1 : 0;
    int s = (sel != 0) ? 2 : 1;
    int len = (1 + DW + p + s) * C;
    logic [63:0] exp = '0, act = '0;
    int done_n = 0, done_at = -1, w = 0, bitn;
    bit busy_bad = 0;
    for (int k = 0; k < len; k++) begin
      bitn = k / C;
      if (bitn == 0)                 exp[k] = 1'b0;
      else if (bitn <= DW)           exp[k] = b[bitn-1];
      else if (p == 1 && bitn == DW + 1) exp[k] = ^b;
      else                           exp[k] = 1'b1;
    end
    @(negedge clk);
    while (cur_tx(sel) !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 300) begin
      failures++;
      $display("FAIL %s start_timeout actual=no_start_bit required=start_within_300", name);
      return;
    end
    for (int k = 0; k < len; k++) begin
      act[k] = cur_tx(sel);
      if (cur_done(sel) === 1'b1) begin done_n++; done_at = k; end
      if (cur_busy(sel) !== 1'b1) busy_bad = 1;
      @(negedge clk);
    end
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tx_wave actual=%h required=%h", name, act, exp);
    end
    checks++;
    if (done_n != 1 || done_at != len - 1) begin
      failures++;
      $display("FAIL %s frame_done pulses=%0d at=%0d required=1 at %0d", name, done_n, done_at, len - 1);
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL %s busy_in_frame actual=dropped required=high", name);
    end
    checks++;
    if ({cur_busy(sel), cur_tx(sel), cur_done(sel)} !== 3'b010) begin
      failures++;
      $display("FAIL %s idle_after actual busy,tx,done=%b required=010", name,
               {cur_busy(sel), cur_tx(sel), cur_done(sel)});
    end
  endtask

  task automatic check_pops(input int sel, input int base, input int n, input string name);
    checks++;
    if (cur_rd(sel) - base != n) begin
      failures++;
      $display("FAIL %s pop_count actual=%0d required=%0d", name, cur_rd(sel) - base, n);
    end
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_a, busy_a, rd_a, done_a} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_a actual=%b required=1000", {tx_a, busy_a, rd_a, done_a});
    end
    checks++;
    if ({tx_b, busy_b, rd_b, done_b} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_b actual=%b required=1000", {tx_b, busy_b, rd_b, done_b});
    end
    push(0, 8'h5A);
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    base = rd_cnt_a;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_pop actual=%b required=0", rd_a);
    end
    check_frame(0, 8'h5A, "after_reset");
    check_pops(0, base, 1, "after_reset");
  endtask

  task automatic test_known();
    int base;
    base = rd_cnt_a;
    push(0, 8'hA5);
    check_frame(0, 8'hA5, "a5_8n1");
    check_pops(0, base, 1, "a5_8n1");
    en_b = 1'b1;
    base = rd_cnt_b;
    push(1, 8'h07);
    check_frame(1, 8'h07, "parity_07");
    push(1, 8'h00);
    check_frame(1, 8'h00, "stop2_00");
    check_pops(1, base, 2, "known_b");
  endtask

  task automatic test_back_to_back();
    int base = rd_cnt_a;
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    check_frame(0, 8'h01, "b2b_0");
    check_frame(0, 8'h02, "b2b_1");
    check_frame(0, 8'h03, "b2b_2");
    check_pops(0, base, 3, "b2b");
    checks++;
    if (under_a != 0) begin
      failures++;
      $display("FAIL b2b_underflow actual=%0d required=0", under_a);
    end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    for (int i = 0; i < 6; i++) begin
      int sel = $urandom_range(0, 1);
      int n = $urandom_range(1, 3);
      int base = cur_rd(sel);
      bytes.delete();
      for (int j = 0; j < n; j++) begin
        bytes.push_back(8'($urandom));
        push(sel, bytes[j]);
      end
      for (int j = 0; j < n; j++) check_frame(sel, bytes[j], "random");
      check_pops(sel, base, n, "random");
    end
    checks++;
    if (under_a + under_b != 0) begin
      failures++;
      $display("FAIL random_underflow actual=%0d required=0", under_a + under_b);
    end
  endtask

  task automatic test_empty();
    bit bad_rd = 0, bad_tx = 0;
    en_a = 1'b1; en_b = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_a !== 1'b0 || rd_b !== 1'b0) bad_rd = 1;
      if (tx_a !== 1'b1 || tx_b !== 1'b1) bad_tx = 1;
    end
    checks++;
    if (bad_rd) begin failures++; $display("FAIL empty_rd_en actual=pulsed required=0"); end
    checks++;
    if (bad_tx) begin failures++; $display("FAIL empty_tx actual=low required=1"); end
  endtask

  task automatic test_enable_hold();
    int base = rd_cnt_a, w = 0;
    bit bad = 0;
    push(0, 8'h3E); push(0, 8'hC1);
    while (rd_cnt_a == base && w < 50) begin @(negedge clk); w++; end
    en_a = 1'b0;
    check_frame(0, 8'h3E, "en_hold_0");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL en_blocked actual=started required=idle"); end
    check_pops(0, base, 1, "en_blocked");
    en_a = 1'b1;
    check_frame(0, 8'hC1, "en_hold_1");
    check_pops(0, base, 2, "en_resume");
  endtask

  task automatic test_reset_mid();
    int base, w = 0;
    push(0, 8'hA5);
    @(negedge clk);
    while (tx_a !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    repeat (C + 3 * C + 1) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_a, busy_a, rd_a, done_a} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_mid actual=%b required=1000", {tx_a, busy_a, rd_a, done_a});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = rd_cnt_a;
    push(0, 8'h96);
    check_frame(0, 8'h96, "reset_mid_fresh");
    check_pops(0, base, 1, "reset_mid_fresh");
  endtask

  initial begin
    test_reset();
    test_known();
    test_back_to_back();
    test_random();
    test_empty();
    test_enable_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the serial data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit, legal minimum 4.
REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits, legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit, the system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port fifo_empty, input, 1 bit, the upstream sync FIFO empty flag (registered, one cycle stale after a pop).
REQ-008 SHALL have port fifo_dout, input, DATA_WIDTH bits, the upstream FIFO read data, valid the cycle after a fifo_rd_en pulse.
REQ-009 SHALL have port fifo_rd_en, output, 1 bit, a single-cycle pop request to the FIFO.
REQ-010 SHALL have port tx_enable, input, 1 bit; when 1, a new frame may start.
REQ-011 SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit, high from the pop until the end of the last stop bit.
REQ-013 SHALL have port frame_done, output, 1 bit, a one-cycle pulse on the final cycle of the last stop bit.

Function
REQ-014 SHALL implement states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE -> POP SHALL occur when tx_enable=1 and fifo_empty=0; otherwise the block SHALL stay in IDLE with tx=1.
REQ-016 In POP, fifo_rd_en SHALL be 1 for exactly one cycle; it SHALL be 0 in every other state.
REQ-017 LOAD SHALL last one cycle and SHALL capture fifo_dout into an internal shift register, because the FIFO's dout is valid on that cycle.
REQ-018 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-019 DATA SHALL send DATA_WIDTH bits, LSB first, each for CLKS_PER_BIT cycles.
REQ-020 PARITY SHALL be entered only when PARITY_EN=1; it SHALL drive the XOR of the data bits for CLKS_PER_BIT cycles.
REQ-021 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-022 The block SHALL spend at least one cycle in IDLE between frames, so the stale fifo_empty after a pop is never sampled.
REQ-023 Frame length from the first START cycle SHALL be (1+DATA_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-024 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL count 0..DATA_WIDTH-1.
REQ-025 Deasserting tx_enable mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->POP transition.
REQ-026 fifo_empty changes after POP SHALL be ignored until the block is back in IDLE.
REQ-027 tx SHALL be driven from a register (glitch-free).

Reset
REQ-028 On rst=1, the state SHALL be IDLE, tx=1, busy=0, fifo_rd_en=0, frame_done=0, and all counters and the shift register SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 with no partial stop bit), and the popped byte SHALL be lost.
REQ-030 After rst deasserts, the first pop SHALL occur no earlier than the second rising clk edge.

Structure
REQ-031 A shared package SHALL hold the state enum type and the parity/stop-bit encoding constants.
REQ-032 The bit-period counter SHALL be one sub-module, uart_baud_tick, producing a one-cycle tick at count CLKS_PER_BIT-1, with a synchronous clear issued in LOAD.
REQ-033 The RTL SHALL integrate directly with sync_fifo (rd_en/dout/empty) without glue logic.

Verification
REQ-034 Write 0xA5 into sync_fifo with CLKS_PER_BIT=4 and tx_enable=1 -> tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; one fifo_rd_en pulse; frame_done after 40 cycles.
REQ-035 Write 3 bytes 0x01,0x02,0x03 back-to-back -> exactly 3 fifo_rd_en pulses, frames in order, an IDLE gap of ≥1 cycle between frames, and no FIFO underflow pop.
REQ-036 PARITY_EN=1 with byte 0x07 -> parity bit=1; frame length 11*CLKS_PER_BIT cycles.
REQ-037 STOP_BITS=2 with byte 0x00 -> tx high for 2*CLKS_PER_BIT cycles after the last data bit.
REQ-038 FIFO empty with tx_enable=1 for 100 cycles -> fifo_rd_en=0 and tx=1 throughout.
REQ-039 Assert rst during DATA bit 3 -> tx=1 and busy=0 the same cycle; a fresh frame starts correctly after release.
